// File: rtl/sync_fifo_wconv.sv
// sync_fifo_wconv: single-clock FIFO packing narrow write words LSB-first into RATIO-wide read words
module sync_fifo_wconv #(
  parameter int WR_WIDTH   = 8,
  parameter int RATIO      = 2,
  parameter int DEPTH      = 256,
  parameter int SHOW_AHEAD = 0,
  parameter int AFULL_TH   = DEPTH - 8,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic                              wr_req,
  input  logic [WR_WIDTH-1:0]               wr_data,
  input  logic                              rd_req,
  input  logic                              err_clr,
  output logic [WR_WIDTH*RATIO-1:0]         rd_data,
  output logic                              wr_full,
  output logic                              wr_almost_full,
  output logic [$clog2(DEPTH):0]            wr_usedw,
  output logic                              rd_empty,
  output logic                              rd_almost_empty,
  output logic [$clog2(DEPTH/RATIO):0]      rd_usedw,
  output logic                              overflow,
  output logic                              underflow
);
  localparam int RD_WIDTH = WR_WIDTH * RATIO;
  localparam int ENTRIES  = DEPTH / RATIO;
  localparam int LW       = $clog2(RATIO);
  localparam int PW       = $clog2(DEPTH) + 1;
  localparam int RW       = $clog2(ENTRIES) + 1;
  localparam int AW       = ENTRIES > 1 ? $clog2(ENTRIES) : 1;
  localparam int SW       = RATIO > 1 ? LW : 1;

  logic [RD_WIDTH-1:0] mem [ENTRIES];
  logic [RD_WIDTH-1:0] rd_q;
  logic [PW-1:0]       wr_ptr;
  logic [RW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_idx, rd_idx;
  logic [SW-1:0]       lane;
  logic [PW-1:0]       wr_nxt;
  logic [RW-1:0]       rd_nxt;
  logic                wr_acc, rd_acc;

  // Acceptance uses only registered flags, so an entry completed this cycle cannot be popped yet
  assign wr_acc = wr_req && !wr_full;
  assign rd_acc = rd_req && !rd_empty;
  assign wr_idx = AW'((wr_ptr >> LW) % ENTRIES);
  assign rd_idx = AW'(rd_ptr % ENTRIES);
  assign lane   = SW'(wr_ptr % RATIO);
  assign wr_nxt = wr_usedw + PW'(wr_acc) - (rd_acc ? PW'(RATIO) : PW'(0));
  assign rd_nxt = RW'(wr_nxt >> LW);
  assign rd_data = SHOW_AHEAD != 0 ? (rd_empty ? '0 : mem[rd_idx]) : rd_q;

  // Storage writes one lane of the current entry; contents survive reset
  always_ff @(posedge sys_clk)
    if (wr_acc) mem[wr_idx][lane*WR_WIDTH +: WR_WIDTH] <= wr_data;

  // Pointers, counts, flags, registered read data and sticky errors
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      wr_usedw        <= '0;
      rd_usedw        <= '0;
      wr_full         <= 1'b0;
      rd_empty        <= 1'b1;
      wr_almost_full  <= (AFULL_TH == 0);
      rd_almost_empty <= 1'b1;
      rd_q            <= '0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (rd_acc) rd_q <= mem[rd_idx];
      wr_usedw        <= wr_nxt;
      rd_usedw        <= rd_nxt;
      wr_full         <= wr_nxt == PW'(DEPTH);
      rd_empty        <= rd_nxt == '0;
      wr_almost_full  <= 32'(wr_nxt) >= AFULL_TH;
      rd_almost_empty <= 32'(rd_nxt) <= AEMPTY_TH;
      overflow        <= (wr_req && wr_full) || (overflow && !err_clr);
      underflow       <= (rd_req && rd_empty) || (underflow && !err_clr);
    end
  end
endmodule
